wptr_handler: RTL
=================

// Module: wptr_handler
// PURPOSE
//  Write-side pointer/flag logic of the async FIFO; the counterpart of the read-pointer/empty logic.
//  - Runs entirely in the write clock domain.
//  - Owns the binary and Gray write pointers.
//  - Synchronises the read Gray pointer into this domain.
//  - Produces full, almost_full, fill level, write-accept and sticky overflow.
//  - b_wptr addresses the dual-port RAM; g_wptr crosses to the read domain.
// PARAMETERS
//  PTR_WIDTH  3  FIFO depth = 2**PTR_WIDTH entries; pointers are PTR_WIDTH+1 bits; legal range >= 2
//  AF_THRESH  6  almost_full asserts when fill level >= AF_THRESH; legal range 1..2**PTR_WIDTH
// PORTS
//  clk_w      in   1            write-domain clock; all flops on posedge
//  arst_n     in   1            asynchronous reset, active low; one clock domain only
//  w_en       in   1            write request from producer
//  ovf_clr    in   1            single-cycle pulse; clears overflow
//  g_rptr     in   PTR_WIDTH+1  read Gray pointer, asynchronous to clk_w
//  b_wptr     out  PTR_WIDTH+1  binary write pointer, registered; RAM address = b_wptr[PTR_WIDTH-1:0]
//  g_wptr     out  PTR_WIDTH+1  Gray write pointer, registered; sent to read domain
//  w_accept   out  1            w_en & ~full, combinational; RAM write enable
//  full       out  1            FIFO full, registered
//  almost_full out 1            fill level >= AF_THRESH, registered
//  wlevel     out  PTR_WIDTH+1  fill level 0..2**PTR_WIDTH, registered, pessimistic
//  overflow   out  1            sticky: a write was attempted while full
// BEHAVIOUR
//  - Reset (arst_n=0): takes effect immediately, with no clock edge needed.
//    Reset values: b_wptr=0, g_wptr=0, both sync stages=0, full=0, almost_full=0, wlevel=0, overflow=0.
//    Reset asserted mid-operation discards all state.
//  - Synchroniser: g_rptr passes through two clk_w flops to give g_rptr_sync.
//    No other logic may sample g_rptr directly.
//  - Read pointer decode: b_rptr_sync = Gray-to-binary(g_rptr_sync), i.e. XOR-prefix from the MSB.
//  - Next pointers:
//    b_wptr_next = b_wptr + (w_en & ~full), modulo 2**(PTR_WIDTH+1).
//    g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
//    Both pointers register on every clk_w edge.
//  - Full, registered:
//    full <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
//    full asserts on the same edge that commits the write filling the last entry.
//  - Level: wlevel <= b_wptr_next - b_rptr_sync, modulo 2**(PTR_WIDTH+1).
//    almost_full <= (that same value >= AF_THRESH).
//  - Overflow: set on any edge where w_en & full.
//    Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
//    A rejected write never moves the pointers.
//  - Pessimism: a read-side pointer change reaches full/wlevel 3 clk_w edges after g_rptr changes
//    (2 synchroniser edges + 1 flag register).
//    full may stay asserted longer than necessary, but never deasserts early.
//  - Wrap-around: the pointer MSB toggles every 2**PTR_WIDTH writes.
//    Gray code guarantees a single-bit change per increment, including 2**(PTR_WIDTH+1)-1 -> 0.
//  - Simultaneous write and read-pointer update: both are applied in the same level computation,
//    so the level is unchanged when one entry is written and one is read.
// TESTING (PTR_WIDTH=3, AF_THRESH=6)
//  1. Reset: pulse arst_n low between edges -> all outputs 0 immediately, before any clk_w edge.
//  2. Fill: g_rptr=0, 8 writes -> b_wptr steps 1..8, g_wptr=4'b1100 after the 8th write.
//     full=1 on the 8th edge; wlevel=8; almost_full=1 from the edge where wlevel becomes 6.
//  3. Overflow: when full, w_en=1 for 1 cycle -> w_accept=0, b_wptr stays 8, overflow=1.
//     Pulse ovf_clr -> overflow=0. Set together with ovf_clr in the same cycle -> overflow=1.
//  4. Drain release: when full, g_rptr 0000->0001 -> full=0 and wlevel=7 exactly on the 3rd clk_w edge.
//  5. Wrap: 20 writes with g_rptr tracking 2 entries behind -> b_wptr 15->0 and g_wptr 1000->0000,
//     with each g_wptr step changing exactly 1 bit; full never asserts.
//  6. Reset mid-fill: after 5 writes, assert arst_n=0 -> b_wptr=0, wlevel=0, almost_full=0.
//     After release, the first write gives b_wptr=1.

Source files
------------

// File: rtl/wptr_handler_if.sv
// wptr_handler_if
//   Bundles the write-side FIFO control/status signals.
//   master : producer / read-domain side (drives w_en, ovf_clr, g_rptr)
//   slave  : wptr_handler (drives pointers and flags)
//   Signals:
//     w_en        write request from producer
//     ovf_clr     single-cycle pulse, clears overflow
//     g_rptr      read Gray pointer, asynchronous to the write clock
//     b_wptr      binary write pointer (RAM address = low PTR_WIDTH bits)
//     g_wptr      Gray write pointer, crosses to the read domain
//     w_accept    RAM write enable (w_en & ~full)
//     full        FIFO full
//     almost_full fill level >= threshold
//     wlevel      pessimistic fill level
//     overflow    sticky: write attempted while full
interface wptr_handler_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 w_en;
  logic                 ovf_clr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 w_accept;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wlevel;
  logic                 overflow;

  modport master (
    output w_en, ovf_clr, g_rptr,
    input  b_wptr, g_wptr, w_accept, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  w_en, ovf_clr, g_rptr,
    output b_wptr, g_wptr, w_accept, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_handler.sv
// wptr_handler
//   Write-side pointer and flag logic of an async FIFO. Everything runs on
//   clk_w. Owns the binary/Gray write pointers, brings the read Gray pointer
//   across with a two-flop synchroniser and derives full, almost_full, the
//   fill level, the write accept and a sticky overflow flag.
//   Ports:
//     clk_w   write-domain clock (posedge)
//     arst_n  asynchronous reset, active low
//     wif     wptr_handler_if slave modport (see interface for signal list)
module wptr_handler #(
  parameter int PTR_WIDTH = 3,
  parameter int AF_THRESH = 6
) (
  input  logic           clk_w,
  input  logic           arst_n,
  wptr_handler_if.slave  wif
);

  localparam logic [PTR_WIDTH:0] AF_VAL = AF_THRESH[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] r_b_wptr;
  logic [PTR_WIDTH:0] r_g_wptr;
  logic [PTR_WIDTH:0] r_rptr_s1;
  logic [PTR_WIDTH:0] r_rptr_s2;
  logic [PTR_WIDTH:0] r_wlevel;
  logic               r_full;
  logic               r_almost_full;
  logic               r_overflow;

  logic               w_accept;
  logic [PTR_WIDTH:0] w_b_wptr_next;
  logic [PTR_WIDTH:0] w_g_wptr_next;
  logic [PTR_WIDTH:0] w_b_rptr_sync;
  logic [PTR_WIDTH:0] w_g_rptr_full;
  logic [PTR_WIDTH:0] w_level_next;

  assign w_accept      = wif.w_en & ~r_full;
  assign w_b_wptr_next = r_b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
  assign w_g_wptr_next = (w_b_wptr_next >> 1) ^ w_b_wptr_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_b_rptr_sync = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      w_b_rptr_sync[i] = ^(r_rptr_s2 >> i);
    end
  end

  // The write pointer is one full lap ahead of the read pointer exactly when
  // the top two Gray bits are inverted and the rest match.
  assign w_g_rptr_full = {~r_rptr_s2[PTR_WIDTH:PTR_WIDTH-1], r_rptr_s2[PTR_WIDTH-2:0]};

  // Level uses the post-write pointer against the synchronised (stale) read
  // pointer, so it can only overstate the true fill.
  assign w_level_next = w_b_wptr_next - w_b_rptr_sync;

  always_ff @(posedge clk_w or negedge arst_n) begin
    if (!arst_n) begin
      r_b_wptr      <= '0;
      r_g_wptr      <= '0;
      r_rptr_s1     <= '0;
      r_rptr_s2     <= '0;
      r_wlevel      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_rptr_s1     <= wif.g_rptr;
      r_rptr_s2     <= r_rptr_s1;
      r_b_wptr      <= w_b_wptr_next;
      r_g_wptr      <= w_g_wptr_next;
      r_full        <= (w_g_wptr_next == w_g_rptr_full);
      r_wlevel      <= w_level_next;
      r_almost_full <= (w_level_next >= AF_VAL);
      // Set has priority over a coincident clear so no overflow is lost.
      if (wif.w_en & r_full)
        r_overflow <= 1'b1;
      else if (wif.ovf_clr)
        r_overflow <= 1'b0;
    end
  end

  assign wif.b_wptr      = r_b_wptr;
  assign wif.g_wptr      = r_g_wptr;
  assign wif.w_accept    = w_accept;
  assign wif.full        = r_full;
  assign wif.almost_full = r_almost_full;
  assign wif.wlevel      = r_wlevel;
  assign wif.overflow    = r_overflow;

endmodule
